// File: rtl/shifter_pkg.sv
// ============================================================================
// Module      : shifter_pkg
// Description : Shared defaults, FSM state encoding and direction constants
//               for the multi-cycle shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_AMT_W = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/shift_sequencer_if.sv
// ============================================================================
// Module      : shift_sequencer_if
// Description : START/DONE request interface of the shift sequencer.
//               SHIFT_ROTATE_EN adds the sh_rot request field.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_sequencer_if
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
);

    logic             start;
    logic             sh_dir;
    logic [AMT_W-1:0] sh_amt;
    logic [WIDTH-1:0] d_in;
`ifdef SHIFT_ROTATE_EN
    logic             sh_rot;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d_out;

    modport master (
        output start, sh_dir, sh_amt, d_in,
`ifdef SHIFT_ROTATE_EN
        output sh_rot,
`endif
        input  busy, done, d_out
    );

    modport slave (
        input  start, sh_dir, sh_amt, d_in,
`ifdef SHIFT_ROTATE_EN
        input  sh_rot,
`endif
        output busy, done, d_out
    );

endinterface

`default_nettype wire

// File: rtl/shift_stage.sv
// ============================================================================
// Module      : shift_stage
// Description : Combinational power-of-two shift stage (distance 2^stage).
//               SHIFT_ROTATE_EN adds a rotate mode input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W,
    parameter int STG_W = $clog2(AMT_W)
) (
    input  wire logic [WIDTH-1:0] data_in,
    input  wire logic [STG_W-1:0] stage,
    input  wire logic             dir,
    input  wire logic             en,
`ifdef SHIFT_ROTATE_EN
    input  wire logic             rot,
`endif
    output logic      [WIDTH-1:0] data_out
);

    logic [AMT_W-1:0] w_dist;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_sar;
    logic [WIDTH-1:0] w_shifted;

    assign w_dist = AMT_W'(1) << stage;
    assign w_shl  = data_in << w_dist;
    assign w_sar  = $unsigned($signed(data_in) >>> w_dist);

`ifdef SHIFT_ROTATE_EN
    logic [AMT_W:0]   w_back;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;

    // Bits leaving one end re-enter from the other after WIDTH - dist positions.
    assign w_back = (AMT_W+1)'(WIDTH) - {1'b0, w_dist};
    assign w_rol  = (data_in << w_dist) | (data_in >> w_back);
    assign w_ror  = (data_in >> w_dist) | (data_in << w_back);
`endif

    always_comb begin
        w_shifted = (dir == DIR_RIGHT) ? w_sar : w_shl;
`ifdef SHIFT_ROTATE_EN
        if (rot) begin
            w_shifted = (dir == DIR_RIGHT) ? w_ror : w_rol;
        end
`endif
    end

    assign data_out = en ? w_shifted : data_in;

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle shifter reusing one stage over AMT_W cycles
//               (distances 1,2,4,8,16). Option macro: SHIFT_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    shift_sequencer_if.slave bus
);

    localparam int STG_W = $clog2(AMT_W);
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(AMT_W - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_amt;
    logic             r_dir;
    logic [STG_W-1:0] r_stage;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_stage_out;
`ifdef SHIFT_ROTATE_EN
    logic             r_rot;
`endif

    shift_stage #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W),
        .STG_W (STG_W)
    ) u_stage (
        .data_in  (r_data),
        .stage    (r_stage),
        .dir      (r_dir),
        .en       (r_amt[r_stage]),
`ifdef SHIFT_ROTATE_EN
        .rot      (r_rot),
`endif
        .data_out (w_stage_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_amt   <= '0;
            r_dir   <= DIR_LEFT;
            r_stage <= '0;
            r_dout  <= '0;
`ifdef SHIFT_ROTATE_EN
            r_rot   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts a new request directly for back-to-back issue.
                    if (bus.start) begin
                        r_data  <= bus.d_in;
                        r_amt   <= bus.sh_amt;
                        r_dir   <= bus.sh_dir;
                        r_stage <= '0;
`ifdef SHIFT_ROTATE_EN
                        r_rot   <= bus.sh_rot;
`endif
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_data <= w_stage_out;
                    if (r_stage == LAST_STAGE) begin
                        r_dout  <= w_stage_out;
                        r_state <= ST_DONE;
                    end else begin
                        r_stage <= r_stage + STG_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = (r_state == ST_SHIFT);
    assign bus.done  = (r_state == ST_DONE);
    assign bus.d_out = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Scoreboard bench for shift_sequencer; rotate vectors are
//               added when SHIFT_ROTATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;
    import shifter_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic        dir;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;
    int          cyc;
    logic [31:0] last_dout;
    exp_t        q[$];
    vec_t        vecs[$];

    shift_sequencer_if #(.WIDTH(32), .AMT_W(5)) sif ();

    shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on DONE, otherwise checks that D_OUT holds.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sif.done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: done=1 at cycle %0d with nothing outstanding", cyc);
                end else begin
                    e = q.pop_front();
                    checks++;
                    if (sif.d_out !== e.data) begin
                        errors++;
                        $display("FAIL d_out: got %h expected %h", sif.d_out, e.data);
                    end
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL latency: done at cycle %0d expected %0d", cyc, e.due);
                    end
                    last_dout = e.data;
                end
            end else begin
                checks++;
                if (sif.d_out !== last_dout) begin
                    errors++;
                    $display("FAIL d_out_hold: got %h expected %h", sif.d_out, last_dout);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] d, input logic dir, input logic [4:0] amt,
                         input logic rot, input bit accept, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        sif.start  = 1'b1;
        sif.d_in   = d;
        sif.sh_dir = dir;
        sif.sh_amt = amt;
`ifdef SHIFT_ROTATE_EN
        sif.sh_rot = rot;
`else
        if (rot) $display("note: rotate request ignored in this build");
`endif
        if (accept) begin
            e.data = exp;
            e.due  = cyc + 6;
            q.push_back(e);
        end
        @(negedge clk);
        sif.start  = 1'b0;
        sif.d_in   = 32'hA5A5_A5A5;
        sif.sh_dir = ~dir;
        sif.sh_amt = 5'd7;
`ifdef SHIFT_ROTATE_EN
        sif.sh_rot = ~rot;
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results still outstanding", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int bc;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        last_dout  = '0;
        rst_n      = 1'b0;
        sif.start  = 1'b0;
        sif.sh_dir = DIR_LEFT;
        sif.sh_amt = '0;
        sif.d_in   = '0;
`ifdef SHIFT_ROTATE_EN
        sif.sh_rot = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks += 3;
        if (sif.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", sif.busy); end
        if (sif.done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", sif.done); end
        if (sif.d_out !== '0)   begin errors++; $display("FAIL reset_dout: got %h expected 0", sif.d_out); end
        rst_n = 1'b1;

        // Left shift by 5 with busy-width check.
        issue(32'h0000_0001, DIR_LEFT, 5'd5, 1'b0, 1'b1, 32'h0000_0020);
        bc = sif.busy ? 1 : 0;
        repeat (5) begin
            @(negedge clk);
            if (sif.busy) bc++;
        end
        checks++;
        if (bc != 5) begin errors++; $display("FAIL busy_cycles: got %0d expected 5", bc); end
        drain();

        vecs.push_back('{32'h8000_0000, DIR_RIGHT, 5'd4,  32'hF800_0000});
        vecs.push_back('{32'h7FFF_FFFF, DIR_RIGHT, 5'd31, 32'h0000_0000});
        vecs.push_back('{32'hDEAD_BEEF, DIR_LEFT,  5'd0,  32'hDEAD_BEEF});
        vecs.push_back('{32'hDEAD_BEEF, DIR_RIGHT, 5'd0,  32'hDEAD_BEEF});
        vecs.push_back('{32'hDEAD_BEEF, DIR_LEFT,  5'd31, 32'h8000_0000});
        vecs.push_back('{32'h8000_0000, DIR_RIGHT, 5'd31, 32'hFFFF_FFFF});
        vecs.push_back('{32'h1234_5678, DIR_LEFT,  5'd8,  32'h3456_7800});
        vecs.push_back('{32'h1234_5678, DIR_RIGHT, 5'd16, 32'h0000_1234});
        vecs.push_back('{32'hF000_0000, DIR_RIGHT, 5'd12, 32'hFFFF_0000});
        vecs.push_back('{32'hA5A5_A5A5, DIR_LEFT,  5'd3,  32'h2D2D_2D28});
        foreach (vecs[i]) begin
            issue(vecs[i].d, vecs[i].dir, vecs[i].amt, 1'b0, 1'b1, vecs[i].exp);
            drain();
        end

        // START during SHIFT must be ignored.
        issue(32'h0000_00F0, DIR_LEFT, 5'd4, 1'b0, 1'b1, 32'h0000_0F00);
        issue(32'hFFFF_FFFF, DIR_RIGHT, 5'd1, 1'b0, 1'b0, 32'h0);
        drain();

        // Back-to-back: second START lands in the DONE cycle.
        issue(32'h0000_0003, DIR_LEFT, 5'd2, 1'b0, 1'b1, 32'h0000_000C);
        repeat (4) @(negedge clk);
        issue(32'h8000_0001, DIR_RIGHT, 5'd1, 1'b0, 1'b1, 32'hC000_0000);
        drain();

        // Asynchronous reset in the third SHIFT cycle discards the operation.
        issue(32'h0000_0001, DIR_LEFT, 5'd31, 1'b0, 1'b1, 32'h8000_0000);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (sif.busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b expected 0", sif.busy); end
        if (sif.done !== 1'b0) begin errors++; $display("FAIL async_rst_done: got %b expected 0", sif.done); end
        if (sif.d_out !== '0)  begin errors++; $display("FAIL async_rst_dout: got %h expected 0", sif.d_out); end
        q.delete();
        last_dout = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(32'h0000_0001, DIR_LEFT, 5'd1, 1'b0, 1'b1, 32'h0000_0002);
        drain();

`ifdef SHIFT_ROTATE_EN
        issue(32'h0000_0001, DIR_RIGHT, 5'd1, 1'b1, 1'b1, 32'h8000_0000);
        drain();
        issue(32'h8000_0001, DIR_LEFT, 5'd4, 1'b1, 1'b1, 32'h0000_0018);
        drain();
        issue(32'h1234_5678, DIR_RIGHT, 5'd8, 1'b1, 1'b1, 32'h7812_3456);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
